reg_file_demux: RTL and testbench
=================================

Name: reg_file_demux

Overview:
- Register bank for the simple processor: 2^ADDR_W registers, each DATA_W wide.
- The write side decodes one address and steers a single write-data bus into exactly one register; this is the demultiplexing direction of the operand-select muxes.
- The read side drives two operand ports for the ALU datapath.
- Sits between instruction decode/write-back and the ALU operand muxes.

Parameters:
- DATA_W, 8, width of each register and of the data buses
- ADDR_W, 3, address width; register count = 2^ADDR_W (8 by default)

Ports:
- CLK  input  1  system clock; all writes on rising edge
- RESET  input  1  asynchronous, active-low reset
- IN  input  DATA_W  write-back data
- INADDRESS  input  ADDR_W  destination register select (write demux select)
- WRITE  input  1  write enable
- BUSYWAIT  input  1  memory stall; high suppresses the write
- OUT1ADDRESS  input  ADDR_W  read port 1 select
- OUT2ADDRESS  input  ADDR_W  read port 2 select
- OUT1  output  DATA_W  read port 1 data
- OUT2  output  DATA_W  read port 2 data

Behaviour:
- Storage: array REG[0 .. 2^ADDR_W-1], each DATA_W bits. No hardwired-zero register.
- Reset:
  - RESET low clears every register to 0 immediately, without waiting for CLK.
  - OUT1 and OUT2 read 0 while RESET is low.
  - Writes are ignored while RESET is low, including a rising edge during reset. Reset wins over a simultaneous write.
  - After RESET deasserts, the first write can occur on the next CLK rising edge.
- Write:
  - On a CLK rising edge, if RESET=1, WRITE=1 and BUSYWAIT=0, then REG[INADDRESS] <= IN.
  - Exactly one register changes per write; all others hold.
  - WRITE=0 or BUSYWAIT=1 at the edge means no register changes.
  - WRITE, INADDRESS and IN are sampled only at the edge; glitches between edges have no effect.
- Read:
  - Combinational: OUT1 = REG[OUT1ADDRESS], OUT2 = REG[OUT2ADDRESS].
  - Any address change is reflected without waiting for a clock.
  - Both ports may select the same register; both then return the same value.
- Read-during-write, same address (without the optional feature):
  - Before the edge, the port shows the old value.
  - From the edge onward, it shows the new value (zero-cycle write-to-read latency after the edge).
- Latency: write-to-read is 1 edge; read is 0 cycles.
- Width: IN stores unmodified; no sign extension or truncation. All addresses are in range by construction (full decode of ADDR_W bits, no wrap logic needed).
- BUSYWAIT held high for N cycles holds the pending write until the first edge with BUSYWAIT=0, provided WRITE stays high. The register file itself keeps no pending state.

Optional Feature:
- Macro: REG_BYPASS_EN
- Defined:
  - If WRITE=1, BUSYWAIT=0, RESET=1 and OUTnADDRESS==INADDRESS, then OUTn = IN combinationally in the same cycle, before the edge.
  - Each port bypasses independently.
  - Removes the read-after-write hazard for the back-to-back instruction.
- Undefined: reads return stored contents only, as in Behaviour.
- Reset behaviour is identical in both builds; bypass is disabled while RESET=0.

Test Plan:
- Reset clears all registers:
  - Stimulus: write 0x55 to all 8 registers, then pulse RESET low mid-cycle.
  - Required response: OUT1/OUT2 read 0x00 for every address immediately, before the next CLK edge.
- Basic write and read-back:
  - Stimulus: WRITE=1, INADDRESS=3, IN=0xA7, one edge; then OUT1ADDRESS=3, OUT2ADDRESS=3.
  - Required response: both read 0xA7. Other registers still read 0x00.
- Write suppression:
  - Stimulus: WRITE=1, BUSYWAIT=1, INADDRESS=5, IN=0x3C for 3 edges.
  - Required response: REG5 stays 0x00. Dropping BUSYWAIT gives REG5=0x3C after the next edge.
- No spurious write:
  - Stimulus: WRITE=0, IN=0xFF, sweep INADDRESS 0-7 over 8 edges.
  - Required response: no register changes.
- Simultaneous reset and write:
  - Stimulus: RESET low across an edge with WRITE=1, INADDRESS=2, IN=0x11.
  - Required response: REG2=0x00 after RESET releases.
- Read-during-write, same address:
  - Stimulus: REG6=0x10; write IN=0x20 to address 6 with OUT1ADDRESS=6.
  - Required response before the edge: OUT1=0x10 without the macro, 0x20 with REG_BYPASS_EN.
  - Required response after the edge: OUT1=0x20 in both builds.

Source files
------------

// File: rtl/reg_file_demux.sv
// reg_file_demux
//   Register bank of 2**ADDR_W registers, DATA_W bits each. One write port
//   steers IN into the register chosen by INADDRESS. Two combinational read
//   ports feed the ALU operand muxes.
//
// Ports
//   CLK          in   system clock, writes on the rising edge
//   RESET        in   asynchronous active-low reset, clears every register
//   IN           in   write-back data
//   INADDRESS    in   destination register select
//   WRITE        in   write enable
//   BUSYWAIT     in   memory stall, high suppresses the write
//   OUT1ADDRESS  in   read port 1 select
//   OUT2ADDRESS  in   read port 2 select
//   OUT1         out  read port 1 data
//   OUT2         out  read port 2 data
//
// Build option
//   REG_BYPASS_EN  when defined, a read port whose address matches an
//                  enabled write forwards IN combinationally before the edge.
//                  When undefined, the read ports show stored contents only.

module reg_file_demux #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // A stalled write is simply not committed; the producer keeps WRITE high
  // until BUSYWAIT drops, so no pending state is kept here.
  assign wr_en = RESET && WRITE && !BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[INADDRESS] <= IN;
    end
  end

  always_comb begin
    OUT1 = regs[OUT1ADDRESS];
    OUT2 = regs[OUT2ADDRESS];
`ifdef REG_BYPASS_EN
    // Each port forwards independently, closing the back-to-back RAW hazard.
    if (wr_en && (OUT1ADDRESS == INADDRESS)) OUT1 = IN;
    if (wr_en && (OUT2ADDRESS == INADDRESS)) OUT2 = IN;
`endif
    // Registers are already cleared during reset; gating here keeps the ports
    // at zero even in the delta before the clear settles.
    if (!RESET) begin
      OUT1 = '0;
      OUT2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_demux.sv
`timescale 1ns/1ps

module tb_reg_file_demux;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSYWAIT;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [8];
  logic [7:0] pre_edge_exp;

  reg_file_demux #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .IN(IN),
    .INADDRESS(INADDRESS),
    .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1),
    .OUT2(OUT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input int a, input logic [7:0] d);
    @(negedge CLK);
    WRITE = 1'b1;
    INADDRESS = a[2:0];
    IN = d;
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
    model[a] = d;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = 3'(i);
      OUT2ADDRESS = 3'(7 - i);
      #1;
      check($sformatf("%s_p1_r%0d", tag, i), OUT1, model[i]);
      check($sformatf("%s_p2_r%0d", tag, 7 - i), OUT2, model[7 - i]);
    end
  endtask

  initial begin
`ifdef REG_BYPASS_EN
    pre_edge_exp = 8'h20;
`else
    pre_edge_exp = 8'h10;
`endif
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    RESET = 1'b0;
    IN = 8'h00;
    INADDRESS = 3'd0;
    WRITE = 1'b0;
    BUSYWAIT = 1'b0;
    OUT1ADDRESS = 3'd0;
    OUT2ADDRESS = 3'd7;
    #1;
    check("reset_out1", OUT1, 8'h00);
    check("reset_out2", OUT2, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;

    // Fill every register with 0x55, then reset mid-cycle.
    for (int i = 0; i < 8; i++) write_reg(i, 8'h55);
    check_all("fill55");
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    // Four address pairs in 4 ns, all before the next rising edge.
    for (int i = 0; i < 4; i++) begin
      OUT1ADDRESS = 3'(i);
      OUT2ADDRESS = 3'(i + 4);
      #1;
      check($sformatf("async_clr_p1_r%0d", i), OUT1, 8'h00);
      check($sformatf("async_clr_p2_r%0d", i + 4), OUT2, 8'h00);
    end

    // Reset held low across an edge with a write pending.
    WRITE = 1'b1;
    INADDRESS = 3'd2;
    IN = 8'h11;
    @(posedge CLK);
    @(negedge CLK);
    WRITE = 1'b0;
    RESET = 1'b1;
    OUT1ADDRESS = 3'd2;
    #1;
    check("reset_beats_write_r2", OUT1, 8'h00);
    check_all("after_reset");

    // Basic write and read-back on both ports.
    write_reg(3, 8'hA7);
    OUT1ADDRESS = 3'd3;
    OUT2ADDRESS = 3'd3;
    #1;
    check("basic_p1_r3", OUT1, 8'hA7);
    check("basic_p2_r3", OUT2, 8'hA7);
    check_all("basic_others");

    // Stalled write held for three edges, then released.
    @(negedge CLK);
    WRITE = 1'b1;
    BUSYWAIT = 1'b1;
    INADDRESS = 3'd5;
    IN = 8'h3C;
    OUT1ADDRESS = 3'd5;
    repeat (3) @(posedge CLK);
    #1;
    check("busywait_r5_held", OUT1, 8'h00);
    @(negedge CLK);
    BUSYWAIT = 1'b0;
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
    model[5] = 8'h3C;
    #1;
    check("busywait_release_r5", OUT1, 8'h3C);

    // WRITE low sweep: nothing may change.
    IN = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      INADDRESS = 3'(i);
      @(posedge CLK);
    end
    #1;
    check_all("no_spurious");

    // A WRITE pulse entirely between edges must not commit.
    @(negedge CLK);
    INADDRESS = 3'd1;
    IN = 8'h99;
    #1 WRITE = 1'b1;
    #1 WRITE = 1'b0;
    @(posedge CLK);
    #1;
    OUT1ADDRESS = 3'd1;
    #1;
    check("glitch_r1", OUT1, 8'h00);

    // Full-width values at both address extremes.
    write_reg(0, 8'h80);
    write_reg(7, 8'hFF);
    OUT1ADDRESS = 3'd0;
    OUT2ADDRESS = 3'd7;
    #1;
    check("edge_r0", OUT1, 8'h80);
    check("edge_r7", OUT2, 8'hFF);

    // Read-during-write on the same address; port 2 watches another register.
    write_reg(6, 8'h10);
    @(negedge CLK);
    OUT1ADDRESS = 3'd6;
    OUT2ADDRESS = 3'd3;
    WRITE = 1'b1;
    INADDRESS = 3'd6;
    IN = 8'h20;
    #1;
    check("rdw_pre_p1_r6", OUT1, pre_edge_exp);
    check("rdw_pre_p2_r3", OUT2, 8'hA7);
    @(posedge CLK);
    #1;
    check("rdw_post_p1_r6", OUT1, 8'h20);
    WRITE = 1'b0;
    model[6] = 8'h20;
    #1;
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
